uart_fifo_core: RTL and testbench
=================================

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
Parameters:
REQ-001 BAUD_DIV, 27, sysclk cycles per 1/16-bit oversample tick (>=2).
REQ-002 DATA_BITS, 8, frame data bits (5..8).
REQ-003 PARITY_EN, 0, 1 = parity bit appended/checked.
REQ-004 PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0).
REQ-005 FIFO_DEPTH, 16, entries per TX and RX FIFO (power of 2, >=2).
Ports:
REQ-006 sysclk  in  1  sole clock, all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high; clears all state.
REQ-008 UART_RX  in  1  serial input, asynchronous to sysclk.
REQ-009 UART_TX  out  1  serial output, idle high.
REQ-010 tx_data  in  DATA_BITS  word to transmit.
REQ-011 tx_wr  in  1  one-cycle push of tx_data into TX FIFO.
REQ-012 tx_full  out  1  TX FIFO full.
REQ-013 tx_busy  out  1  TX FIFO non-empty or frame in progress.
REQ-014 rx_data  out  DATA_BITS  head of RX FIFO (first-word-fall-through).
REQ-015 rx_rd  in  1  one-cycle pop of RX FIFO head.
REQ-016 rx_empty  out  1  RX FIFO empty.
REQ-017 rx_frame_err  out  1  head entry had bad stop bit.
REQ-018 rx_parity_err  out  1  head entry had parity mismatch.
REQ-019 rx_overrun  out  1  sticky: a received frame was dropped, RX FIFO full.

Function
REQ-020 Tick generator SHALL pulse one sysclk cycle every BAUD_DIV cycles; bit period = 16 ticks.
REQ-021 Frame format SHALL be start(0), DATA_BITS LSB-first, optional parity, one stop(1).
REQ-022 TX FSM states IDLE, START, DATA, PARITY, STOP; each non-IDLE state holds UART_TX for exactly 16 ticks; PARITY skipped when PARITY_EN=0.
REQ-023 TX SHALL leave IDLE on the first tick with TX FIFO non-empty, popping the word then; back-to-back frames SHALL have no idle gap.
REQ-024 UART_RX SHALL pass a 2-flop synchroniser; RX logic uses synchronised value only.
REQ-025 RX FSM states IDLE, START, DATA, PARITY, STOP; falling edge in IDLE starts tick count; line re-sampled at tick 8: if high, return to IDLE (glitch), no FIFO write.
REQ-026 Each data/parity/stop bit SHALL be sampled once at tick 8 of its bit period.
REQ-027 At stop sample RX SHALL push {data, frame_err, parity_err} in that cycle, then IDLE; a low stop bit sets frame_err and RX waits for line high before re-arming.
REQ-028 rx_frame_err/rx_parity_err SHALL reflect the head entry, 0 when rx_empty=1.
REQ-029 tx_wr while tx_full=1 SHALL be ignored; rx_rd while rx_empty=1 SHALL be ignored.
REQ-030 RX push with RX FIFO full SHALL drop the frame and set rx_overrun; rx_overrun clears on next accepted rx_rd.
REQ-031 Simultaneous push and pop on a full or empty FIFO: full -> both occur, count unchanged; empty -> pop ignored, push occurs.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from a count or extra pointer bit, never ambiguous.
REQ-033 Flags (tx_full, rx_empty) SHALL update the cycle after the causing push/pop.

Reset
REQ-034 On reset assertion, immediately: UART_TX=1, tx_full=0, tx_busy=0, rx_empty=1, rx_data=0, all error flags 0, FSMs IDLE, FIFOs empty, tick counter 0.
REQ-035 Reset mid-frame SHALL abort the frame; UART_TX returns high asynchronously; partial RX data discarded.
REQ-036 After deassertion both FSMs SHALL stay IDLE until a new trigger (FIFO data / falling edge).

Verification (BAUD_DIV=4, DATA_BITS=8, FIFO_DEPTH=4; bit = 64 cycles)
REQ-037 Write 0x55 -> UART_TX low 64 cycles, then 1,0,1,0,1,0,1,0 at 64 cycles each, stop high; tx_busy drops after stop.
REQ-038 Loop UART_TX to UART_RX, write 0xA3,0x00,0xFF -> rx_data pops 0xA3,0x00,0xFF, no error flags.
REQ-039 PARITY_EN=1, PARITY_ODD=0, drive 0x07 with parity 0 -> entry 0x07, rx_parity_err=1.
REQ-040 Drive 5 frames with no rx_rd -> 4 entries held, rx_overrun=1; one rx_rd clears it.
REQ-041 Drive 0x3C with stop bit low -> rx_frame_err=1 with head 0x3C; 20-cycle low glitch on idle line -> no entry.
REQ-042 Assert reset at DATA bit 3 of a TX frame -> UART_TX=1 same cycle, tx_busy=0, no further frame.

Source files
------------

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: full-duplex UART with TX and RX FIFOs.
//
// The transmitter pops words from a TX FIFO and serialises them as
// start(0), DATA_BITS LSB-first, an optional parity bit and one stop(1).
// The receiver synchronises UART_RX, deserialises frames and pushes each
// word into an RX FIFO together with its frame-error and parity-error bits.
// The RX FIFO is first-word-fall-through.
//
// Ports:
//   sysclk        in   sole clock, rising edge
//   reset         in   asynchronous, active-high, clears all state
//   UART_RX       in   serial input (asynchronous to sysclk)
//   UART_TX       out  serial output, idle high
//   tx_data       in   word to transmit
//   tx_wr         in   one-cycle push into TX FIFO (ignored when full)
//   tx_full       out  TX FIFO full
//   tx_busy       out  TX FIFO non-empty or frame in progress
//   rx_data       out  head of RX FIFO (0 when empty)
//   rx_rd         in   one-cycle pop of RX FIFO head (ignored when empty)
//   rx_empty      out  RX FIFO empty
//   rx_frame_err  out  head entry had a low stop bit
//   rx_parity_err out  head entry had a parity mismatch
//   rx_overrun    out  sticky: a frame was dropped because RX FIFO was full

// Synchronous FIFO with a show-ahead read port. Full/empty come from an
// occupancy count so they are never ambiguous when the pointers meet.
module uart_fifo_core_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == C_FULL);
  assign w_pop_ok  = i_pop && !o_empty;
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

module uart_fifo_core #(
  parameter int BAUD_DIV   = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic                 UART_TX,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_rd,
  output logic                 rx_empty,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);
  localparam int TICK_W = $clog2(BAUD_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  C_LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic              C_PAR_EN    = (PARITY_EN != 0);
  localparam logic              C_PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Oversample tick generator
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == C_TICK_LAST);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Transmit path
  logic [DATA_BITS-1:0] w_tx_head;
  logic                 w_tx_empty;
  logic                 w_tx_pop;
  tx_state_t            r_tx_state;
  logic [3:0]           r_tx_cnt;
  logic [BIT_W-1:0]     r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_uart_tx;

  uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (sysclk),
    .i_rst   (reset),
    .i_push  (tx_wr),
    .i_data  (tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (tx_full),
    .o_empty (w_tx_empty)
  );

  // A word is taken either from IDLE or at the last tick of a stop bit, so
  // queued words go out back-to-back with no idle gap.
  assign w_tx_pop = w_tick && !w_tx_empty &&
                    ((r_tx_state == TX_IDLE) ||
                     ((r_tx_state == TX_STOP) && (r_tx_cnt == 4'd15)));

  assign UART_TX = r_uart_tx;
  assign tx_busy = !w_tx_empty || (r_tx_state != TX_IDLE);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_uart_tx  <= 1'b1;
    end else if (w_tick) begin
      if (w_tx_pop) begin
        r_tx_state <= TX_START;
        r_tx_cnt   <= '0;
        r_tx_shift <= w_tx_head;
        r_tx_par   <= (^w_tx_head) ^ C_PAR_ODD;
        r_uart_tx  <= 1'b0;
      end else if (r_tx_state == TX_IDLE) begin
        r_uart_tx <= 1'b1;
      end else if (r_tx_cnt != 4'd15) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end else begin
        r_tx_cnt <= '0;
        case (r_tx_state)
          TX_START: begin
            r_tx_state <= TX_DATA;
            r_tx_idx   <= '0;
            r_uart_tx  <= r_tx_shift[0];
          end
          TX_DATA: begin
            if (r_tx_idx == C_LAST_BIT) begin
              if (C_PAR_EN) begin
                r_tx_state <= TX_PARITY;
                r_uart_tx  <= r_tx_par;
              end else begin
                r_tx_state <= TX_STOP;
                r_uart_tx  <= 1'b1;
              end
            end else begin
              r_tx_idx   <= r_tx_idx + 1'b1;
              r_tx_shift <= r_tx_shift >> 1;
              r_uart_tx  <= r_tx_shift[1];
            end
          end
          TX_PARITY: begin
            r_tx_state <= TX_STOP;
            r_uart_tx  <= 1'b1;
          end
          default: begin
            r_tx_state <= TX_IDLE;
            r_uart_tx  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Receive path: two-flop synchroniser, then the bit FSM
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  rx_state_t            r_rx_state;
  logic [3:0]           r_rx_cnt;
  logic [BIT_W-1:0]     r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_perr;
  logic                 r_rx_armed;
  logic                 w_rx_push;
  logic [DATA_BITS+1:0] w_rx_push_data;
  logic [DATA_BITS+1:0] w_rx_head;
  logic                 w_rx_full;
  logic                 w_rx_rd_ok;
  logic                 r_rx_ovr;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  // The stop bit is sampled and the entry pushed in the same cycle.
  assign w_rx_push      = w_tick && (r_rx_state == RX_STOP) && (r_rx_cnt == 4'd15);
  assign w_rx_push_data = {r_rx_shift, !r_rx_sync, r_rx_perr};

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_armed <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          // Armed only after the line has been seen high, so a stuck-low
          // line following a bad stop bit cannot start a new frame.
          if (r_rx_armed && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_armed <= 1'b0;
          end else if (r_rx_sync) begin
            r_rx_armed <= 1'b1;
          end
        end
        RX_START: begin
          // Mid-start check; from here each later bit is 16 ticks away.
          if (w_tick) begin
            if (r_rx_cnt == 4'd7) begin
              r_rx_cnt <= '0;
              if (r_rx_sync) begin
                r_rx_state <= RX_IDLE;
                r_rx_armed <= 1'b1;
              end else begin
                r_rx_state <= RX_DATA;
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rx_cnt == 4'd15) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
              if (r_rx_idx == C_LAST_BIT) r_rx_state <= C_PAR_EN ? RX_PARITY : RX_STOP;
              else                        r_rx_idx   <= r_rx_idx + 1'b1;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (w_tick) begin
            if (r_rx_cnt == 4'd15) begin
              r_rx_cnt   <= '0;
              r_rx_perr  <= (r_rx_sync != ((^r_rx_shift) ^ C_PAR_ODD));
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (w_tick) begin
            if (r_rx_cnt == 4'd15) begin
              r_rx_cnt   <= '0;
              r_rx_state <= RX_IDLE;
              r_rx_armed <= r_rx_sync;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  uart_fifo_core_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (sysclk),
    .i_rst   (reset),
    .i_push  (w_rx_push),
    .i_data  (w_rx_push_data),
    .i_pop   (rx_rd),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (rx_empty)
  );

  assign {rx_data, rx_frame_err, rx_parity_err} = w_rx_head;
  assign w_rx_rd_ok = rx_rd && !rx_empty;
  assign rx_overrun = r_rx_ovr;

  // A push into a full FIFO only lands if a pop happens in the same cycle.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)                                        r_rx_ovr <= 1'b0;
    else if (w_rx_push && w_rx_full && !w_rx_rd_ok)  r_rx_ovr <= 1'b1;
    else if (w_rx_rd_ok)                              r_rx_ovr <= 1'b0;
  end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Randomised bench for uart_fifo_core (BAUD_DIV=4, DATA_BITS=8, FIFO_DEPTH=4,
// so one bit = 64 sysclk cycles). u_dut runs without parity, u_par with even parity.
module tb_uart_fifo_core;
  localparam int BITC = 64;
  localparam int FRAME = 10 * BITC;
  localparam int DEPTH = 4;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // DUT without parity
  logic       r_loop = 1'b0;
  logic       drv_rx = 1'b1;
  logic       w_rx_in;
  logic       UART_TX;
  logic [7:0] tx_data = '0;
  logic       tx_wr = 1'b0;
  logic       tx_full, tx_busy;
  logic [7:0] rx_data;
  logic       rx_rd = 1'b0;
  logic       rx_empty, rx_frame_err, rx_parity_err, rx_overrun;

  assign w_rx_in = r_loop ? UART_TX : drv_rx;

  uart_fifo_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) u_dut (
    .sysclk(sysclk), .reset(reset), .UART_RX(w_rx_in), .UART_TX(UART_TX),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
  );

  // DUT with even parity
  logic       drv_rx_p = 1'b1;
  logic       w_tx_p;
  logic [7:0] tx_data_p = '0;
  logic       tx_wr_p = 1'b0;
  logic       w_full_p, w_busy_p;
  logic [7:0] rx_data_p;
  logic       rd_p = 1'b0;
  logic       rx_empty_p, ferr_p, perr_p, ovr_p;

  uart_fifo_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) u_par (
    .sysclk(sysclk), .reset(reset), .UART_RX(drv_rx_p), .UART_TX(w_tx_p),
    .tx_data(tx_data_p), .tx_wr(tx_wr_p), .tx_full(w_full_p), .tx_busy(w_busy_p),
    .rx_data(rx_data_p), .rx_rd(rd_p), .rx_empty(rx_empty_p), .rx_frame_err(ferr_p),
    .rx_parity_err(perr_p), .rx_overrun(ovr_p)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the RX side: a bounded queue of {data, frame_err, parity_err}
  typedef logic [9:0] ent_t;
  ent_t exp_q[$];
  logic model_ovr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    wait_cyc(1);
    tx_wr   = 1'b0;
  endtask

  task automatic wait_tx_low(output int t0, output logic ok, input int bound);
    ok = 1'b0;
    t0 = cyc;
    for (int i = 0; i < bound; i++) begin
      wait_cyc(1);
      if (UART_TX === 1'b0) begin
        ok = 1'b1;
        t0 = cyc;
        break;
      end
    end
  endtask

  // Samples a frame that started at cycle t0 in the middle of each bit.
  task automatic tx_sample(input int t0, output logic [7:0] d, output logic stopv);
    for (int i = 0; i < 8; i++) begin
      wait_until(t0 + BITC + BITC/2 + i*BITC);
      d[i] = UART_TX;
    end
    wait_until(t0 + 9*BITC + BITC/2);
    stopv = UART_TX;
  endtask

  task automatic set_line(input logic sel, input logic v);
    if (sel) drv_rx_p = v;
    else     drv_rx   = v;
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] d, input logic has_par,
                            input logic par, input logic stopv);
    set_line(sel, 1'b0);
    wait_cyc(BITC);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      wait_cyc(BITC);
    end
    if (has_par) begin
      set_line(sel, par);
      wait_cyc(BITC);
    end
    set_line(sel, stopv);
    wait_cyc(BITC);
    set_line(sel, 1'b1);
    wait_cyc(16);
  endtask

  task automatic model_push(input logic [7:0] d, input logic fe, input logic pe);
    if (exp_q.size() < DEPTH) exp_q.push_back({d, fe, pe});
    else model_ovr = 1'b1;
  endtask

  task automatic pop_check(input logic sel, input ent_t e);
    check_eq("rx_empty_before_pop", sel ? rx_empty_p : rx_empty, 0);
    check_eq("rx_data", sel ? rx_data_p : rx_data, e[9:2]);
    check_eq("rx_frame_err", sel ? ferr_p : rx_frame_err, e[1]);
    check_eq("rx_parity_err", sel ? perr_p : rx_parity_err, e[0]);
    if (sel) rd_p = 1'b1;
    else     rx_rd = 1'b1;
    wait_cyc(1);
    rd_p  = 1'b0;
    rx_rd = 1'b0;
  endtask

  task automatic drain(input logic sel);
    ent_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_check(sel, e);
      model_ovr = 1'b0;
      check_eq("rx_overrun_after_pop", sel ? ovr_p : rx_overrun, model_ovr);
    end
    check_eq("rx_empty_after_drain", sel ? rx_empty_p : rx_empty, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          t0, tk, tprev;
    logic        ok, s;
    logic [7:0]  d, b;
    logic [7:0]  w [5];
    int          errs [10];
    int          lows, busys;
    logic        bad, par;

    // Reset state, checked while reset is held
    #2 reset = 1'b1;
    #1;
    check_eq("rst_uart_tx", UART_TX, 1);
    check_eq("rst_tx_full", tx_full, 0);
    check_eq("rst_tx_busy", tx_busy, 0);
    check_eq("rst_rx_empty", rx_empty, 1);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_errs", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    check_eq("rst_par_dut", {w_tx_p, w_full_p, w_busy_p, rx_empty_p}, 4'b1001);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);

    // 0x55: every bit checked cycle by cycle for its exact 64-cycle width
    b = 8'h55;
    tx_write(b);
    wait_tx_low(t0, ok, 100);
    check_eq("tx55_start_seen", ok, 1);
    for (int i = 0; i < 10; i++) errs[i] = 0;
    for (int k = 0; k < FRAME; k++) begin
      wait_until(t0 + k);
      if (k / BITC == 0)      s = 1'b0;
      else if (k / BITC == 9) s = 1'b1;
      else                    s = b[k / BITC - 1];
      if (UART_TX !== s) errs[k / BITC]++;
      if (k == FRAME - 1) check_eq("tx55_busy_in_stop", tx_busy, 1);
    end
    for (int i = 0; i < 10; i++) check_eq($sformatf("tx55_bit%0d_bad_cycles", i), errs[i], 0);
    wait_until(t0 + FRAME);
    check_eq("tx55_busy_after_stop", tx_busy, 0);
    check_eq("tx55_idle_high", UART_TX, 1);

    // Random burst: FIFO fills, extra write ignored, frames back-to-back
    for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
    tx_write(w[0]);
    wait_tx_low(t0, ok, 100);
    check_eq("burst_start_seen", ok, 1);
    for (int i = 1; i < 5; i++) tx_write(w[i]);
    check_eq("tx_full_set", tx_full, 1);
    tx_write(8'($urandom));
    check_eq("tx_full_hold", tx_full, 1);
    tprev = t0;
    tk = t0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_tx_low(tk, ok, FRAME + 50);
        check_eq("burst_next_start_seen", ok, 1);
        check_eq("burst_no_gap", tk - tprev, FRAME);
      end
      tx_sample(tk, d, s);
      check_eq($sformatf("burst_data%0d", k), d, w[k]);
      check_eq("burst_stop", s, 1);
      tprev = tk;
    end
    wait_until(tk + FRAME);
    check_eq("burst_busy_end", tx_busy, 0);
    check_eq("burst_full_end", tx_full, 0);
    wait_tx_low(t0, ok, FRAME + 100);
    check_eq("burst_no_extra_frame", ok, 0);

    // Loopback: TX feeds RX
    r_loop = 1'b1;
    w[0] = 8'hA3; w[1] = 8'h00; w[2] = 8'hFF; w[3] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      tx_write(w[i]);
      model_push(w[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 4000; i++) begin
      if (!tx_busy) break;
      wait_cyc(1);
    end
    check_eq("loop_tx_done", tx_busy, 0);
    wait_cyc(20);
    drain(1'b0);
    r_loop = 1'b0;
    wait_cyc(20);

    // Bad stop bit, then a short glitch that must not produce an entry
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    model_push(8'h3C, 1'b1, 1'b0);
    drain(1'b0);
    set_line(1'b0, 1'b0);
    wait_cyc(20);
    set_line(1'b0, 1'b1);
    wait_cyc(300);
    check_eq("glitch_no_entry", rx_empty, 1);

    // Overrun: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
      model_push(d, 1'b0, 1'b0);
    end
    check_eq("overrun_set", rx_overrun, model_ovr);
    check_eq("overrun_full_not_empty", rx_empty, 0);
    drain(1'b0);

    // Random mix of good and bad stop bits
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) begin
        d   = 8'($urandom);
        bad = ($urandom_range(0, 3) == 0);
        send_frame(1'b0, d, 1'b0, 1'b0, !bad);
        model_push(d, bad, 1'b0);
      end
      check_eq("mix_overrun", rx_overrun, model_ovr);
      drain(1'b0);
    end

    // Reset in the middle of data bit 3 of a TX frame, with a word still queued
    b = 8'($urandom) & 8'hF7;
    tx_write(b);
    tx_write(8'($urandom));
    wait_tx_low(t0, ok, 100);
    check_eq("rstmid_start_seen", ok, 1);
    wait_until(t0 + BITC + 3*BITC + BITC/2);
    check_eq("rstmid_bit3_low", UART_TX, 0);
    #2 reset = 1'b1;
    #1;
    check_eq("rstmid_uart_tx_high", UART_TX, 1);
    check_eq("rstmid_busy_clear", tx_busy, 0);
    check_eq("rstmid_full_clear", tx_full, 0);
    exp_q.delete();
    model_ovr = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    lows  = 0;
    busys = 0;
    for (int i = 0; i < 1500; i++) begin
      wait_cyc(1);
      if (UART_TX !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busys++;
    end
    check_eq("rstmid_no_frame_low_cycles", lows, 0);
    check_eq("rstmid_no_busy_cycles", busys, 0);
    check_eq("rstmid_rx_empty", rx_empty, 1);

    // Even parity receiver: 0x07 has three ones, so a parity bit of 0 is wrong
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    model_push(8'h07, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 1) == 1);
      par = (^d) ^ bad;
      send_frame(1'b1, d, 1'b1, par, 1'b1);
      model_push(d, 1'b0, bad);
    end
    check_eq("par_overrun", ovr_p, model_ovr);
    drain(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
